// File: rtl/wb_master_seq.sv
// wb_master_seq: Wishbone classic-cycle initiator.
// Turns single-word commands from a valid/ready command port into Wishbone bus
// cycles and returns read data or completion status on a valid/ready response
// port. A per-transaction ack timeout keeps unmapped addresses (never acked by
// the decoder) from hanging the initiator.
//
// Ports:
//   wbs_clk_i, wbs_rst_n_i            clock, async active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i,
//   cmd_sel_i                         command payload
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_dat_o, rsp_err_o              read data (0 on write/timeout), timeout flag
//   wbm_cyc_o, wbm_stb_o, wbm_we_o,
//   wbm_sel_o, wbm_adr_o, wbm_dat_o   Wishbone request
//   wbm_dat_i, wbm_ack_i              Wishbone reply
//   busy_o                            FSM not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held on rsp_* until rsp_ready_i
module wb_master_seq #(
   parameter int TIMEOUT = 255
) (
   input  logic        wbs_clk_i,
   input  logic        wbs_rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   assign busy_o = (state != IDLE);

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         state       <= IDLE;
         cnt         <= '0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // ready comes up one edge after reset release
               cmd_ready_o <= 1'b1;
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  wbm_cyc_o   <= 1'b1;
                  wbm_stb_o   <= 1'b1;
                  wbm_we_o    <= cmd_we_i;
                  wbm_adr_o   <= cmd_adr_i;
                  wbm_dat_o   <= cmd_dat_i;
                  wbm_sel_o   <= cmd_sel_i;
                  cnt         <= '0;
                  state       <= BUS;
               end
            end
            BUS: begin
               // an ack in the last allowed cycle wins over the timeout
               if (wbm_ack_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (cnt == CNT_LAST) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_dat_o   <= 32'h0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq: directed bench for wb_master_seq (TIMEOUT=8) with a
// response scoreboard and a small Wishbone slave model driven per cycle.
module tb_wb_master_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic [31:0] slave_dat;
   logic        slave_ack, stray_ack, ack;
   logic        busy;

   assign ack = slave_ack | stray_ack;

   always #5 clk = ~clk;

   wb_master_seq #(.TIMEOUT(8)) dut (
      .wbs_clk_i(clk), .wbs_rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(slave_dat),
      .wbm_ack_i(ack), .busy_o(busy)
   );

   typedef struct {
      logic [31:0] dat;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   int          total = 0, bad = 0;
   int          cyc_n = 0, acc_cycle = 0, accepts = 0;
   int          cyc_len = 0, last_len = 0;
   logic        was_cyc = 1'b0, acc_flag = 1'b0;
   logic [31:0] exp_adr = 32'h0;
   int          slave_wait = -1, scnt = 0;
   logic [31:0] slave_rdata = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: score handshakes seen before the edge, then observe after it
   // and drive the slave reply for the next edge.
   task automatic step();
      logic cmd_hs, rsp_hs;
      rsp_t e;
      cmd_hs = cmd_valid && cmd_ready;
      rsp_hs = rsp_valid && rsp_ready;
      if (rsp_hs) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL rsp_unexpected: observed=response expected=none");
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_dat", rsp_dat, e.dat);
            chk("sb_err", 32'(rsp_err), 32'(e.err));
         end
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (cmd_hs) begin
         accepts++;
         acc_flag  = 1'b1;
         acc_cycle = cyc_n;
      end
      if (cyc) begin
         cyc_len++;
         was_cyc = 1'b1;
         chk("adr_stable", adr, exp_adr);
      end else if (was_cyc) begin
         last_len = cyc_len;
         cyc_len  = 0;
         was_cyc  = 1'b0;
      end
      if (cyc && stb) begin
         if (slave_wait >= 0 && scnt == slave_wait) begin
            slave_ack = 1'b1;
            slave_dat = slave_rdata;
         end else begin
            slave_ack = 1'b0;
         end
         scnt++;
      end else begin
         slave_ack = 1'b0;
         scnt      = 0;
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int wt, input logic [31:0] rd,
                        input logic [31:0] edat, input logic eerr);
      rsp_t e;
      slave_wait  = wt;
      slave_rdata = rd;
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
      cmd_valid = 1'b1;
      e.dat = edat; e.err = eerr;
      exp_q.push_back(e);
      exp_adr  = a;
      acc_flag = 1'b0;
      for (int i = 0; i < 10 && !acc_flag; i++) step();
      cmd_valid = 1'b0;
      chk("accepted", 32'(acc_flag), 32'd1);
      chk("cyc_up", 32'(cyc), 32'd1);
      chk("stb_up", 32'(stb), 32'd1);
      chk("bus_we", 32'(we), 32'(w));
      chk("bus_adr", adr, a);
      chk("bus_dat", dat_o, d);
      chk("bus_sel", 32'(sel), 32'(s));
   endtask

   task automatic wait_rsp(input int exp_len, input logic [31:0] edat, input logic eerr);
      for (int i = 0; i < 30 && !rsp_valid; i++) step();
      chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
      chk("cyc_len", 32'(last_len), 32'(exp_len));
      chk("latency", 32'(cyc_n - acc_cycle), 32'(exp_len));
      chk("cyc_down", 32'(cyc), 32'd0);
      chk("stb_down", 32'(stb), 32'd0);
      chk("rsp_dat", rsp_dat, edat);
      chk("rsp_err", 32'(rsp_err), 32'(eerr));
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_fall", 32'(rsp_valid), 32'd0);
      chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
      chk("busy_after_rsp", 32'(busy), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   int          a0, idx;
   int          times[4];
   logic [31:0] b2b_adr[4];
   rsp_t        e;

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0; slave_ack = 1'b0; stray_ack = 1'b0; slave_dat = '0;
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_cyc", 32'(cyc), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_adr", adr, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      chk("ready_in_release", 32'(cmd_ready), 32'd0);
      step();
      chk("ready_after_release", 32'(cmd_ready), 32'd1);

      // write, immediate ack
      issue(1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h5555_5555, 32'h0, 1'b0);
      wait_rsp(1, 32'h0, 1'b0);
      finish_rsp();

      // read, ack after 3 wait cycles
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'h1234_5678, 32'h1234_5678, 1'b0);
      wait_rsp(4, 32'h1234_5678, 1'b0);
      finish_rsp();

      // unmapped read, timeout
      issue(1'b0, 32'h4000_0000, 32'h0, 4'h3, -1, 32'h0, 32'h0, 1'b1);
      wait_rsp(8, 32'h0, 1'b1);
      finish_rsp();

      // ack in the 8th (last) bus cycle, then a held response
      issue(1'b0, 32'h3800_0100, 32'h0, 4'hC, 7, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);
      wait_rsp(8, 32'hA5A5_0F0F, 1'b0);
      a0 = accepts;
      cmd_we = 1'b1; cmd_adr = 32'h3800_0200; cmd_dat = 32'h0; cmd_valid = 1'b1;
      stray_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_dat", rsp_dat, 32'hA5A5_0F0F);
         chk("hold_err", 32'(rsp_err), 32'd0);
         chk("hold_ready", 32'(cmd_ready), 32'd0);
         chk("hold_cyc", 32'(cyc), 32'd0);
      end
      chk("hold_no_accept", 32'(accepts - a0), 32'd0);
      cmd_valid = 1'b0;
      stray_ack = 1'b0;
      finish_rsp();

      // async reset mid-BUS
      issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, -1, 32'h0, 32'h0, 1'b1);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cyc", 32'(cyc), 32'd0);
      chk("arst_stb", 32'(stb), 32'd0);
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      cyc_len = 0;
      was_cyc = 1'b0;
      step();
      rst_n = 1'b1;
      chk("arst_ready_held", 32'(cmd_ready), 32'd0);
      step();
      chk("arst_ready_up", 32'(cmd_ready), 32'd1);
      issue(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
      wait_rsp(2, 32'h0BAD_F00D, 1'b0);
      finish_rsp();

      // back-to-back with both valids held high
      a0 = accepts;
      slave_wait = 0;
      rsp_ready = 1'b1;
      idx = 0;
      for (int i = 0; i < 4; i++) b2b_adr[i] = 32'h3800_1000 + 32'(i * 4);
      cmd_we = 1'b0; cmd_adr = b2b_adr[0]; cmd_dat = 32'hC0DE_0000; cmd_sel = 4'hF;
      slave_rdata = 32'h1000_0000;
      exp_adr = b2b_adr[0];
      e.dat = 32'h1000_0000; e.err = 1'b0;
      exp_q.push_back(e);
      cmd_valid = 1'b1;
      for (int i = 0; i < 40 && idx < 4; i++) begin
         acc_flag = 1'b0;
         step();
         if (acc_flag) begin
            times[idx] = acc_cycle;
            chk("b2b_order", adr, b2b_adr[idx]);
            idx++;
            if (idx < 4) begin
               cmd_we      = idx[0];
               cmd_adr     = b2b_adr[idx];
               cmd_dat     = 32'hC0DE_0000 + 32'(idx);
               slave_rdata = 32'h1000_0000 + 32'(idx);
               exp_adr     = b2b_adr[idx];
               e.dat = idx[0] ? 32'h0 : 32'h1000_0000 + 32'(idx);
               e.err = 1'b0;
               exp_q.push_back(e);
            end
         end
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rsp_ready = 1'b0;
      chk("b2b_count", 32'(accepts - a0), 32'd4);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(times[i] - times[i-1]), 32'd3);
      chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("b2b_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_master_seq.md
# wb_master_seq

Wishbone classic-cycle initiator that converts single-word commands from a valid/ready command port into Wishbone bus cycles. It returns each cycle's read data or completion status on a valid/ready response port. It drives the slave side of the user-project Wishbone address decoder, which serves windows 0x30xx_xxxx (Wishbone-to-AXI bridge) and 0x38xx_xxxx (exmem). A per-transaction ack timeout keeps an unmapped address from hanging the initiator, because the decoder never acks such addresses.

## Interface
- TIMEOUT, 255: maximum consecutive bus cycles spent waiting for ack; legal range is 1 to 65535.
- wbs_clk_i  in  1  single clock for all logic.
- wbs_rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted on any edge where valid and ready are both 1.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lane selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed on any edge where valid and ready are both 1.
- rsp_dat_o  out  32  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  1 = the transaction timed out.
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle and strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from the decoder.
- wbm_ack_i  in  1  ack from the decoder.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- IDLE:
  - cmd_ready_o=1.
  - On acceptance, latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the timeout counter, go to BUS.
- BUS:
  - cyc, stb, we, sel, adr and dat_o are held stable every cycle; cmd_ready_o=0.
  - Edge with wbm_ack_i=1:
    - Drop cyc and stb.
    - Read: rsp_dat_o<=wbm_dat_i. Write: rsp_dat_o<=0.
    - rsp_err_o<=0; rsp_valid_o<=1; go to RESP.
  - Edge with wbm_ack_i=0:
    - If the counter equals TIMEOUT-1: drop cyc and stb; rsp_dat_o<=0; rsp_err_o<=1; rsp_valid_o<=1; go to RESP.
    - Otherwise increment the counter.
  - Net effect: cyc/stb are high for at most TIMEOUT cycles. An ack in the final (TIMEOUT-th) cycle wins over the timeout.
- RESP:
  - Hold rsp_valid_o, rsp_dat_o and rsp_err_o stable until rsp_ready_i=1.
  - On that edge, clear rsp_valid_o and go to IDLE.
  - rsp_dat_o and rsp_err_o keep their values after the handshake; they are only meaningful while rsp_valid_o=1.
- wbm_ack_i outside BUS is ignored and causes no state change.
- wbm_dat_o and wbm_we_o keep their last values between cycles. wbm_sel_o and wbm_adr_o are likewise held. Only cyc and stb qualify the bus.
- Counter width is clog2(TIMEOUT+1) bits. It never wraps: it is cleared on entry to BUS and stops at TIMEOUT-1.

## Timing
- Reset (wbs_rst_n_i=0, applied at any time, including mid-BUS):
  - Immediately, without waiting for a clock edge: all outputs are 0 and the state is IDLE.
  - cmd_ready_o is 0 while reset is asserted and becomes 1 on the first edge after release.
  - An in-flight bus cycle is abandoned with no response.
- Command acceptance: a command accepted at edge N has cyc/stb visible from edge N to edge N+1.
- Minimum latency: when ack is high in the first bus cycle, rsp_valid_o rises at edge N+1 and cyc/stb fall at the same edge. So cyc/stb are high for exactly 1 cycle.
- Ack after k wait cycles (k < TIMEOUT): cyc/stb are high for k+1 cycles; rsp_valid_o rises at edge N+k+1.
- Timeout: rsp_valid_o with rsp_err_o=1 rises at edge N+TIMEOUT.
- A response accepted at edge M sets cmd_ready_o=1 from edge M. The next command is accepted at the earliest at edge M+1.
- Peak throughput is one transaction per 3 cycles.

## Test plan
- Write 0x3800_0004, data 0xDEAD_BEEF, sel 0xF; slave acks in the first cycle -> exactly 1 cycle of cyc=stb=we=1 with adr/dat/sel matching; rsp_valid_o at the next edge with rsp_err_o=0 and rsp_dat_o=0.
- Read 0x3000_0010; ack after 3 wait cycles with wbm_dat_i=0x1234_5678 -> cyc/stb high for 4 cycles with stable adr; rsp_dat_o=0x1234_5678; rsp_err_o=0.
- Read 0x4000_0000 with TIMEOUT=8 and no ack -> cyc/stb high for exactly 8 cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
- TIMEOUT=8, ack in bus cycle 8 -> success (rsp_err_o=0). Then hold rsp_ready_i=0 for 5 cycles -> response stable, cmd_ready_o=0, a new cmd_valid_i is not accepted, and stray acks are ignored.
- Assert wbs_rst_n_i=0 mid-BUS, asynchronously -> cyc, stb and rsp_valid_o go to 0 without a clock edge. After release, cmd_ready_o=1 at the first edge and a fresh read completes normally.
- Back-to-back: 4 commands with cmd_valid_i held high and rsp_ready_i held high, each slave acks immediately -> each command is accepted exactly once, in order, at a 3-cycle spacing.
